// File: rtl/carry_chain_sched.sv
// Round-robin scheduler sharing one SEG-bit ripple segment between NREQ requesters.
// Optional signed-overflow output enabled by CARRY_CHAIN_SCHED_OVF_EN.
module carry_chain_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic                       C,
    input  logic                       R,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WIDTH-1:0]      req_a,
    input  logic [NREQ*WIDTH-1:0]      req_b,
    input  logic [NREQ-1:0]            req_sub,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout
`ifdef CARRY_CHAIN_SCHED_OVF_EN
    ,
    output logic                       rsp_ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;
    localparam int IW   = $clog2(NREQ);
    localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     rr;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              cy;
    logic [SW-1:0]     seg;

    logic [IW-1:0]     gnt;
    logic              hit;
    int                idx;

    logic [SEG-1:0]    sa;
    logic [SEG-1:0]    sb;
    logic [SEG-1:0]    sp;
    logic [SEG-1:0]    sg;
    logic [SEG-1:0]    ssum;
    logic [SEG:0]      c;

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        gnt = '0;
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr) + i) % NREQ;
            if (!hit && req_valid[idx]) begin
                hit = 1'b1;
                gnt = IW'(idx);
            end
        end
    end

    // Accept strobe: one-hot on the grant, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && hit && !R) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // One segment of the shared ripple chain.
    always_comb begin
        sa   = a_q[seg*SEG +: SEG];
        sb   = b_q[seg*SEG +: SEG];
        sp   = sa ^ sb;
        sg   = sa & sb;
        c    = '0;
        c[0] = cy;
        ssum = '0;
        for (int k = 0; k < SEG; k++) begin
            ssum[k]  = sp[k] ^ c[k];
            c[k+1]   = sp[k] ? c[k] : sg[k];
        end
    end

    // Control FSM, operand capture and segment-serial result assembly.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state     <= IDLE;
            rr        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cy        <= 1'b0;
            seg       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef CARRY_CHAIN_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        a_q    <= req_a[gnt*WIDTH +: WIDTH];
                        b_q    <= req_sub[gnt] ? ~req_b[gnt*WIDTH +: WIDTH]
                                               :  req_b[gnt*WIDTH +: WIDTH];
                        cy     <= req_sub[gnt];
                        rsp_id <= gnt;
                        seg    <= '0;
                        rr     <= (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    rsp_sum[seg*SEG +: SEG] <= ssum;
                    cy <= c[SEG];
                    if (seg == SW'(NSEG-1)) begin
                        rsp_cout  <= c[SEG];
`ifdef CARRY_CHAIN_SCHED_OVF_EN
                        rsp_ovf   <= c[SEG] ^ c[SEG-1];
`endif
                        rsp_valid <= 1'b1;
                        seg       <= '0;
                        state     <= DONE;
                    end else begin
                        seg <= seg + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
